// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler: FSM states,
// grant encoding and the fixed banner ROM.
package uart_sched_pkg;

    localparam int unsigned BANNER_LEN = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_IDLE
    } state_t;

    typedef enum logic {
        GNT_ECHO = 1'b0,
        GNT_MSG  = 1'b1
    } grant_t;

    // "ROLLUP\r\n"
    function automatic logic [7:0] banner_byte(input logic [31:0] i);
        logic [7:0] b;
        case (i)
            32'd0:   b = 8'h52;
            32'd1:   b = 8'h4F;
            32'd2:   b = 8'h4C;
            32'd3:   b = 8'h4C;
            32'd4:   b = 8'h55;
            32'd5:   b = 8'h50;
            32'd6:   b = 8'h0D;
            32'd7:   b = 8'h0A;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Byte handshake between the scheduler (master) and uart_tx (slave).
interface uart_tx_sched_if;

    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;

    modport master (
        output tx_start,
        output tx_data,
        input  tx_busy
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output tx_busy
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with head-of-queue output; a push while full is accepted
// only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             wr_en;
    logic             rd_en;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one uart_tx between the RX echo FIFO and the key-triggered banner,
// round-robin at unit boundaries; a banner is never split by echo bytes.
module uart_tx_sched
    import uart_sched_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned MSG_LEN    = BANNER_LEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              echo_valid,
    input  logic [7:0]        echo_data,
    input  logic              msg_req,
    uart_tx_sched_if.master   tx,
    output logic              echo_full,
    output logic              echo_ovf,
    output logic              msg_busy
);

    localparam int unsigned IDX_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

    state_t           state;
    grant_t           last_grant;
    logic             msg_pend;
    logic [IDX_W-1:0] idx;
    logic             tx_start_q;
    logic [7:0]       tx_data_q;

    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic [7:0]       fifo_dout;
    logic             msg_grant;
    logic             idx_last;

    // On a tie the requester that did not win last time takes the grant
    assign fifo_pop  = (state == S_IDLE) && !fifo_empty &&
                       (!msg_pend || (last_grant == GNT_MSG));
    assign msg_grant = (state == S_IDLE) && msg_pend &&
                       (fifo_empty || (last_grant == GNT_ECHO));
    assign fifo_push = echo_valid && (!echo_full || fifo_pop);
    assign idx_last  = (idx == IDX_W'(MSG_LEN - 1));
    assign msg_busy  = msg_pend || ((last_grant == GNT_MSG) && (state != S_IDLE));

    assign tx.tx_start = tx_start_q;
    assign tx.tx_data  = tx_data_q;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_echo_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   (echo_data),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (echo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            last_grant <= GNT_MSG;
            msg_pend   <= 1'b0;
            idx        <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            echo_ovf   <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            if (echo_valid && !fifo_push) begin
                echo_ovf <= 1'b1;
            end
            if (msg_req && !msg_busy) begin
                msg_pend <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (fifo_pop) begin
                        tx_data_q  <= fifo_dout;
                        last_grant <= GNT_ECHO;
                        state      <= S_ISSUE;
                    end else if (msg_grant) begin
                        tx_data_q  <= banner_byte(32'd0);
                        msg_pend   <= 1'b0;
                        idx        <= '0;
                        last_grant <= GNT_MSG;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    tx_start_q <= 1'b1;
                    state      <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (tx.tx_busy) begin
                        state <= S_WAIT_IDLE;
                    end
                end
                S_WAIT_IDLE: begin
                    if (!tx.tx_busy) begin
                        // Remaining banner bytes follow without re-arbitration
                        if ((last_grant == GNT_MSG) && !idx_last) begin
                            idx       <= idx + 1'b1;
                            tx_data_q <= banner_byte(32'(idx) + 32'd1);
                            state     <= S_ISSUE;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Scheduler that shares the single UART transmitter (uart_tx byte interface, 9600 baud at 50 MHz) between two sources: the RX echo path, buffered in an internal 8-entry FIFO, and a fixed 8-byte banner message triggered by the debounced key pulse. It sits in top between uart_rx / key debounce and uart_tx, sequencing one byte at a time through the tx_start / tx_busy handshake. Arbitration is round-robin at unit boundaries; a message is never interleaved with echo bytes.

## Interface
- FIFO_DEPTH, 8, echo FIFO depth in bytes (power of 2)
- MSG_LEN, 8, banner length in bytes
- clk  input  1  system clock, 50 MHz
- rst_n  input  1  asynchronous active-low reset
- echo_valid  input  1  one-cycle pulse: echo_data is a received byte to echo
- echo_data  input  8  received byte
- msg_req  input  1  one-cycle pulse from key debounce: send banner
- tx_busy  input  1  uart_tx busy, high while a frame is shifting
- tx_start  output  1  one-cycle pulse: uart_tx loads tx_data
- tx_data  output  8  byte to transmit, held stable from tx_start until tx_busy falls
- echo_full  output  1  echo FIFO full
- echo_ovf  output  1  sticky: an echo byte was dropped; cleared only by reset
- msg_busy  output  1  banner pending or in progress

## Operation
- Banner ROM, fixed: 0x52 0x4F 0x4C 0x4C 0x55 0x50 0x0D 0x0A ("ROLLUP\r\n").
- msg_req sets msg_pend; ignored while msg_pend or banner in progress (no queueing).
- echo_valid pushes echo_data if FIFO not full, or if full and a pop occurs the same cycle; otherwise the byte is dropped and echo_ovf is set.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_IDLE.
- IDLE: requesters are echo (FIFO non-empty) and msg (msg_pend). Only one → grant it. Both → grant the one not equal to last_grant. Grant loads tx_data (echo: pop FIFO head; msg: ROM[0], clear msg_pend, idx=0), updates last_grant → ISSUE.
- ISSUE: tx_start=1 for exactly one cycle → WAIT_BUSY.
- WAIT_BUSY: wait for tx_busy=1 → WAIT_IDLE.
- WAIT_IDLE: wait for tx_busy=0. If msg granted and idx<MSG_LEN-1: idx+1, tx_data=ROM[idx+1] → ISSUE (no arbitration). Otherwise → IDLE.
- msg_busy = msg_pend | (grant==msg & state!=IDLE).
- Reset mid-operation: all state, FIFO, msg_pend, idx cleared; partial banner abandoned; tx_start low in first cycle after deassertion.

## Timing
- Reset values: tx_start=0, tx_data=0x00, echo_full=0, echo_ovf=0, msg_busy=0, state=IDLE, last_grant=msg (echo wins first tie).
- echo_valid sampled at edge k with scheduler idle and empty FIFO → tx_start high in the cycle after edge k+2.
- msg_req at edge k, idle → msg_busy high after edge k, tx_start high after edge k+2.
- Between bytes of one banner: tx_start one cycle after tx_busy is seen low.
- Simultaneous echo_valid and msg_req in IDLE with empty FIFO: both registered; next grant by round-robin.
- FIFO pointers wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.
- tx_busy never rising after tx_start is a uart_tx fault; the scheduler waits indefinitely in WAIT_BUSY.

## Structure
- Package uart_sched_pkg: state enum, grant encoding (GNT_ECHO, GNT_MSG), banner ROM constant, MSG_LEN.
- Sub-module sync_fifo (width 8, depth FIFO_DEPTH; push, pop, full, empty, dout = head); instantiated once for echo.
- Scheduler FSM, banner index and round-robin pointer live in uart_tx_sched.

## Test plan
- Single echo: echo_valid with 0x41, uart_tx model busy 5208 cycles per frame → one tx_start with tx_data=0x41; msg_busy stays 0.
- Banner: msg_req pulse → 8 tx_start pulses, data 0x52,0x4F,0x4C,0x4C,0x55,0x50,0x0D,0x0A in order, msg_busy falls after final tx_busy falls.
- Contention: msg_req and echo 0x31, 0x32 in same idle cycle → 0x31, full banner, then 0x32; no echo byte inside banner.
- Overflow: 10 echo pushes while banner in progress → echo_full high after 8th, echo_ovf set, 8 bytes echoed in push order after banner.
- Ignored request: second msg_req during banner → exactly 8 banner bytes total.
- Reset mid-banner: assert rst_n low after 3rd byte's tx_start → all outputs reset values, no further tx_start until new request.
